// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM sequencer: packet function codes, FSM states
// and the WAIT_RISE limit.
package pwm_pkg;

    localparam logic [7:0] FuncSlotWr  = 8'h03;
    localparam logic [7:0] FuncSeqCtrl = 8'h04;

    localparam int unsigned WaitRiseLimit = 16;
    localparam int unsigned WaitCntW      = $clog2(WaitRiseLimit);

    localparam logic [7:0] ChanUnused = 8'hFF;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLaunch   = 3'd1,
        StWaitRise = 3'd2,
        StRun      = 3'd3,
        StGap      = 3'd4,
        StNext     = 3'd5
    } seq_state_e;

endpackage

// File: rtl/pwm_slot_ram.sv
// Schedule table: _SLOTS entries of {chan[7:0], gap[15:0]}, one write port and
// an asynchronous read port.
module pwm_slot_ram
    import pwm_pkg::*;
#(
    parameter int unsigned _SLOTS = 8
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [23:0] wdata,
    input  logic [2:0]  raddr,
    output logic [23:0] rdata
);

    logic [23:0] mem_q [_SLOTS];

    // Empty slots reset to an out-of-range channel so a stray run flags an error.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(_SLOTS); i++) begin
                mem_q[i] <= {ChanUnused, 16'h0000};
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pwm_sequencer.sv
// Steps through a table of {channel, gap} slots, enabling one PWM channel at a
// time and waiting for its busy pulse, for a programmable number of loops.
module pwm_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned _NUM_CHANNELS = 4,
    parameter int unsigned _SLOTS        = 8,
    parameter int unsigned _TMO_WIDTH    = 24
) (
    input  logic                     clk_50M,
    input  logic                     rst_n,
    input  logic [7:0]               func_reg,
    input  logic [7:0]               rev_data1,
    input  logic [7:0]               rev_data2,
    input  logic [7:0]               rev_data3,
    input  logic [7:0]               rev_data4,
    input  logic                     pack_done,
    input  logic [_NUM_CHANNELS-1:0] pwm_busy,
    output logic [_NUM_CHANNELS-1:0] pwm_en,
    output logic                     seq_busy,
    output logic                     seq_done,
    output logic                     seq_err,
    output logic [2:0]               cur_slot
);

    seq_state_e                state_q, state_d;
    logic [_NUM_CHANNELS-1:0]  en_q, en_d;
    logic                      err_q, err_d;
    logic                      done_q, done_d;
    logic [2:0]                slot_q, slot_d;
    logic [7:0]                num_slots_q, num_slots_d;
    logic [7:0]                loops_q, loops_d;
    logic [WaitCntW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [_TMO_WIDTH-1:0]     tmo_q, tmo_d;
    logic [15:0]               gap_cnt_q, gap_cnt_d;

    logic        ctrl_pkt, start_req, abort_req, start_ok, slot_we;
    logic [23:0] slot_rdata;
    logic [7:0]  slot_chan;
    logic [15:0] slot_gap;
    logic        chan_valid, busy_sel, last_slot;
    logic [_NUM_CHANNELS-1:0] chan_oh;

    assign ctrl_pkt  = pack_done && (func_reg == FuncSeqCtrl);
    assign abort_req = ctrl_pkt && rev_data2[1];
    assign start_req = ctrl_pkt && rev_data2[0] && !rev_data2[1];
    assign start_ok  = (rev_data1 != 8'd0) && (rev_data1 <= 8'(_SLOTS));
    assign slot_we   = pack_done && (func_reg == FuncSlotWr) && (state_q == StIdle) &&
                       (rev_data1 < 8'(_SLOTS));

    pwm_slot_ram #(
        ._SLOTS(_SLOTS)
    ) u_slot_ram (
        .clk_50M(clk_50M),
        .rst_n  (rst_n),
        .we     (slot_we),
        .waddr  (rev_data1[2:0]),
        .wdata  ({rev_data2, rev_data3, rev_data4}),
        .raddr  (slot_q),
        .rdata  (slot_rdata)
    );

    assign slot_chan  = slot_rdata[23:16];
    assign slot_gap   = slot_rdata[15:0];
    assign chan_valid = slot_chan < 8'(_NUM_CHANNELS);
    // en_q is one-hot on the active channel, so this picks that channel's busy.
    assign busy_sel   = |(pwm_busy & en_q);
    assign last_slot  = ({5'd0, slot_q} == (num_slots_q - 8'd1));

    always_comb begin
        chan_oh = '0;
        for (int unsigned i = 0; i < _NUM_CHANNELS; i++) begin
            chan_oh[i] = (slot_chan == 8'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        err_d       = err_q;
        done_d      = 1'b0;
        slot_d      = slot_q;
        num_slots_d = num_slots_q;
        loops_d     = loops_q;
        wait_cnt_d  = wait_cnt_q;
        tmo_d       = tmo_q;
        gap_cnt_d   = gap_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    if (start_ok) begin
                        err_d   = 1'b0;
                        slot_d  = 3'd0;
                        state_d = StLaunch;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLaunch: begin
                if (chan_valid) begin
                    en_d       = chan_oh;
                    wait_cnt_d = '0;
                    state_d    = StWaitRise;
                end else begin
                    err_d   = 1'b1;
                    state_d = StNext;
                end
            end
            StWaitRise: begin
                if (busy_sel) begin
                    tmo_d   = '0;
                    state_d = StRun;
                end else if (wait_cnt_q == WaitCntW'(WaitRiseLimit - 1)) begin
                    err_d     = 1'b1;
                    en_d      = '0;
                    gap_cnt_d = 16'd1;
                    state_d   = (slot_gap == 16'd0) ? StNext : StGap;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!busy_sel || (tmo_q == '1)) begin
                    if (busy_sel) begin
                        err_d = 1'b1;
                    end
                    en_d      = '0;
                    gap_cnt_d = 16'd1;
                    state_d   = (slot_gap == 16'd0) ? StNext : StGap;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q == slot_gap) begin
                    state_d = StNext;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            StNext: begin
                if (last_slot) begin
                    slot_d = 3'd0;
                    // loops_q == 0 means run forever.
                    if (loops_q == 8'd1) begin
                        loops_d = 8'd0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        if (loops_q != 8'd0) begin
                            loops_d = loops_q - 8'd1;
                        end
                        state_d = StLaunch;
                    end
                end else begin
                    slot_d  = slot_q + 3'd1;
                    state_d = StLaunch;
                end
            end
            default: state_d = StIdle;
        endcase

        if (ctrl_pkt) begin
            num_slots_d = rev_data1;
            loops_d     = rev_data3;
        end

        if (abort_req && (state_q != StIdle)) begin
            state_d = StIdle;
            en_d    = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            en_q        <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            slot_q      <= 3'd0;
            num_slots_q <= 8'd0;
            loops_q     <= 8'd0;
            wait_cnt_q  <= '0;
            tmo_q       <= '0;
            gap_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            err_q       <= err_d;
            done_q      <= done_d;
            slot_q      <= slot_d;
            num_slots_q <= num_slots_d;
            loops_q     <= loops_d;
            wait_cnt_q  <= wait_cnt_d;
            tmo_q       <= tmo_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign pwm_en   = en_q;
    assign seq_busy = (state_q != StIdle);
    assign seq_done = done_q;
    assign seq_err  = err_q;
    assign cur_slot = slot_q;

endmodule
